// File: rtl/i2s_tx_pkg.sv
// Shared encodings and helpers for the multi-format serial audio transmitter.
package i2s_tx_pkg;

  // Serial formats. The unused encoding 2'b11 is folded onto FMT_LJ when it is latched.
  localparam logic [1:0] FMT_LJ  = 2'b00;
  localparam logic [1:0] FMT_I2S = 2'b01;
  localparam logic [1:0] FMT_RJ  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ceiling log2, used for counter and pointer widths (result is at least 1 for v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Stereo-pair FIFO: first-word-fall-through read, registered full flag, synchronous flush.
module i2s_tx_fifo
  import i2s_tx_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             MCLK_i,
  input  logic             nRST_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int             AW       = clog2(DEPTH);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             do_push, do_pop;

  // full is a register: a pop against a full FIFO only frees the slot from the next cycle.
  assign empty   = (cnt == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this cycle's push/pop/flush.
  always_comb begin
    cnt_nxt = cnt;
    if (flush)                 cnt_nxt = '0;
    else if (do_push & ~do_pop) cnt_nxt = cnt + 1'b1;
    else if (do_pop & ~do_push) cnt_nxt = cnt - 1'b1;
  end

  // Pointers, count and full flag; full stays high through reset so nothing is accepted early.
  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b1;
    end else begin
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == CNT_FULL);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage, no reset needed: entries are only read after being written.
  always_ff @(posedge MCLK_i) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/i2s_multiformat_tx.sv
// Stereo serial audio transmitter: left-justified / I2S / right-justified framing.
// Optional build macro I2S_TX_UNDERRUN_HOLD_EN: repeat the last pair on underrun
// (default build sends zeros instead).
module i2s_multiformat_tx
  import i2s_tx_pkg::*;
#(
  parameter int DATA_W        = 24,
  parameter int SLOT_W        = 32,
  parameter int MCLK_PER_SCLK = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              MCLK_i,
  input  logic              nRST_i,
  input  logic [DATA_W-1:0] PDATA_LEFT_i,
  input  logic [DATA_W-1:0] PDATA_RIGHT_i,
  input  logic              PDATA_VALID_i,
  output logic              PDATA_READY_o,
  input  logic [1:0]        FMT_i,
  input  logic              TX_EN_i,
  output logic              SCLK_o,
  output logic              SDATA_o,
  output logic              LRCLK_o,
  output logic              UNDERRUN_o
);

  localparam int              PAD      = SLOT_W - DATA_W;
  localparam int              MC_W     = clog2(MCLK_PER_SCLK);
  localparam int              BC_W     = clog2(2 * SLOT_W);
  localparam logic [MC_W-1:0] MC_LAST  = MC_W'(MCLK_PER_SCLK - 1);
  localparam logic [MC_W-1:0] MC_HALF  = MC_W'(MCLK_PER_SCLK / 2);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(2 * SLOT_W - 1);
  localparam logic [BC_W-1:0] BIT_RSL  = BC_W'(SLOT_W);

  state_e                state;
  logic [1:0]            fmt_q;
  logic [MC_W-1:0]       mclk_cnt;
  logic [BC_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]     cur_l, cur_r, sub_l, sub_r;
  logic                  dly_bit;
  logic                  fifo_full, fifo_empty;
  logic [2*DATA_W-1:0]   fifo_rd;
  logic                  start, frame_end, pop, flush, left;
  logic [2*SLOT_W-1:0]   frame_lj, frame_rj;
  logic                  lj_bit, rj_bit;

  assign start     = (state == ST_IDLE) & TX_EN_i & ~fifo_empty;
  assign frame_end = (state == ST_RUN) & TX_EN_i & (mclk_cnt == MC_LAST) & (bit_cnt == BIT_LAST);
  assign pop       = start | frame_end;
  assign flush     = (state == ST_RUN) & ~TX_EN_i;
  assign PDATA_READY_o = ~fifo_full;

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  assign sub_l = cur_l;
  assign sub_r = cur_r;
`else
  assign sub_l = '0;
  assign sub_r = '0;
`endif

  // Whole-frame images: LJ pads zeros after the word, RJ sign-extends in front of it.
  assign frame_lj = {SLOT_W'(cur_l) << PAD, SLOT_W'(cur_r) << PAD};
  assign frame_rj = {SLOT_W'($signed(cur_l)), SLOT_W'($signed(cur_r))};
  assign lj_bit   = frame_lj[BIT_LAST - bit_cnt];
  assign rj_bit   = frame_rj[BIT_LAST - bit_cnt];
  assign left     = (bit_cnt < BIT_RSL);

  i2s_tx_fifo #(.WIDTH(2 * DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .MCLK_i  (MCLK_i),
    .nRST_i  (nRST_i),
    .flush   (flush),
    .push    (PDATA_VALID_i),
    .wr_data ({PDATA_LEFT_i, PDATA_RIGHT_i}),
    .full    (fifo_full),
    .pop     (pop),
    .empty   (fifo_empty),
    .rd_data (fifo_rd)
  );

  // Control FSM, counters and registered serial outputs. I2S reuses the LJ bit stream
  // delayed by one SCLK through dly_bit.
  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      state      <= ST_IDLE;
      fmt_q      <= FMT_LJ;
      mclk_cnt   <= '0;
      bit_cnt    <= '0;
      cur_l      <= '0;
      cur_r      <= '0;
      dly_bit    <= 1'b0;
      SCLK_o     <= 1'b1;
      SDATA_o    <= 1'b0;
      LRCLK_o    <= 1'b0;
      UNDERRUN_o <= 1'b0;
    end else begin
      UNDERRUN_o <= 1'b0;
      if (state == ST_IDLE) begin
        fmt_q    <= (FMT_i == FMT_I2S || FMT_i == FMT_RJ) ? FMT_i : FMT_LJ;
        mclk_cnt <= '0;
        bit_cnt  <= '0;
        dly_bit  <= 1'b0;
        SCLK_o   <= 1'b1;
        SDATA_o  <= 1'b0;
        LRCLK_o  <= 1'b0;
        if (start) begin
          state          <= ST_RUN;
          {cur_l, cur_r} <= fifo_rd;
        end
      end else if (!TX_EN_i) begin
        state    <= ST_IDLE;
        mclk_cnt <= '0;
        bit_cnt  <= '0;
        dly_bit  <= 1'b0;
        SCLK_o   <= 1'b1;
        SDATA_o  <= 1'b0;
        LRCLK_o  <= 1'b0;
      end else begin
        if (mclk_cnt == MC_LAST) begin
          mclk_cnt <= '0;
          bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end else begin
          mclk_cnt <= mclk_cnt + 1'b1;
        end
        if (mclk_cnt == '0) begin
          SCLK_o  <= 1'b0;
          dly_bit <= lj_bit;
          SDATA_o <= (fmt_q == FMT_I2S) ? dly_bit : (fmt_q == FMT_RJ) ? rj_bit : lj_bit;
          LRCLK_o <= (fmt_q == FMT_I2S) ? ~left : left;
        end else if (mclk_cnt == MC_HALF) begin
          SCLK_o <= 1'b1;
        end
        if (frame_end) begin
          UNDERRUN_o     <= fifo_empty;
          {cur_l, cur_r} <= fifo_empty ? {sub_l, sub_r} : fifo_rd;
        end
      end
    end
  end

endmodule
